// File: rtl/alu_rr_arbiter.sv
// Shares one ALU between two requesters (A: EX stage, B: branch/aux unit).
// Round-robin grant in IDLE, fixed-latency wait in BUSY, result hand-back in RESP.
module alu_rr_arbiter #(
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 3
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        a_req_valid,
    output logic        a_req_ready,
    input  logic [5:0]  a_opcode,
    input  logic [5:0]  a_func,
    input  logic [4:0]  a_sa,
    input  logic [31:0] a_first,
    input  logic [31:0] a_second,
    output logic        a_resp_valid,
    input  logic        a_resp_ready,

    input  logic        b_req_valid,
    output logic        b_req_ready,
    input  logic [5:0]  b_opcode,
    input  logic [5:0]  b_func,
    input  logic [4:0]  b_sa,
    input  logic [31:0] b_first,
    input  logic [31:0] b_second,
    output logic        b_resp_valid,
    input  logic        b_resp_ready,

    output logic [31:0] resp_result,
    output logic        resp_zero,

    output logic [5:0]  alu_opcode,
    output logic [5:0]  alu_func,
    output logic [4:0]  alu_sa,
    output logic [31:0] alu_first,
    output logic [31:0] alu_second,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,

    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(ALU_LAT);

    state_t            r_state;
    logic              r_rr_ptr;   // 0 = A has priority on a tie, 1 = B
    logic              r_owner;    // 0 = A, 1 = B
    logic [CNT_W-1:0]  r_cnt;
    logic [5:0]        r_alu_opcode;
    logic [5:0]        r_alu_func;
    logic [4:0]        r_alu_sa;
    logic [31:0]       r_alu_first;
    logic [31:0]       r_alu_second;
    logic [31:0]       r_resp_result;
    logic              r_resp_zero;

    logic              w_idle;
    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_accept;
    logic              w_jtype;
    logic              w_resp_done;
    logic [5:0]        w_sel_opcode;
    logic [5:0]        w_sel_func;
    logic [4:0]        w_sel_sa;
    logic [31:0]       w_sel_first;
    logic [31:0]       w_sel_second;

    // Readys are held low while reset is asserted so nothing is accepted mid-reset.
    assign w_idle    = (r_state == S_IDLE) && !rst;
    assign w_grant_b = b_req_valid && (!a_req_valid || r_rr_ptr);
    assign w_grant_a = a_req_valid && !w_grant_b;

    assign a_req_ready = w_idle && w_grant_a;
    assign b_req_ready = w_idle && w_grant_b;
    assign w_accept    = a_req_ready || b_req_ready;

    assign w_sel_opcode = w_grant_b ? b_opcode : a_opcode;
    assign w_sel_func   = w_grant_b ? b_func   : a_func;
    assign w_sel_sa     = w_grant_b ? b_sa     : a_sa;
    assign w_sel_first  = w_grant_b ? b_first  : a_first;
    assign w_sel_second = w_grant_b ? b_second : a_second;
    assign w_jtype      = (w_sel_opcode[5:1] == 5'b00001);

    assign w_resp_done  = (r_state == S_RESP) && (r_owner ? b_resp_ready : a_resp_ready);

    assign a_resp_valid = (r_state == S_RESP) && !r_owner;
    assign b_resp_valid = (r_state == S_RESP) &&  r_owner;
    assign busy         = (r_state != S_IDLE);

    assign resp_result  = r_resp_result;
    assign resp_zero    = r_resp_zero;
    assign alu_opcode   = r_alu_opcode;
    assign alu_func     = r_alu_func;
    assign alu_sa       = r_alu_sa;
    assign alu_first    = r_alu_first;
    assign alu_second   = r_alu_second;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= 1'b0;
            r_owner       <= 1'b0;
            r_cnt         <= '0;
            r_alu_opcode  <= '0;
            r_alu_func    <= '0;
            r_alu_sa      <= '0;
            r_alu_first   <= '0;
            r_alu_second  <= '0;
            r_resp_result <= '0;
            r_resp_zero   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_alu_opcode <= w_sel_opcode;
                        r_alu_func   <= w_sel_func;
                        r_alu_sa     <= w_sel_sa;
                        r_alu_first  <= w_sel_first;
                        r_alu_second <= w_sel_second;
                        r_owner      <= w_grant_b;
                        r_rr_ptr     <= !w_grant_b;
                        // Jumps never use the ALU result; answer immediately with zeros.
                        if (w_jtype) begin
                            r_resp_result <= '0;
                            r_resp_zero   <= 1'b0;
                            r_state       <= S_RESP;
                        end else begin
                            r_cnt   <= LAT_INIT;
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_resp_result <= alu_result;
                        r_resp_zero   <= alu_zero;
                        r_state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (w_resp_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
